// File: rtl/telemetry_framer.sv
// Periodic telemetry packetiser: snapshots NUM_CH channels on each period tick and
// streams DELIM1, DELIM2, channel bytes (MSB first) and an optional checksum to UART_tx.
`timescale 1ns/1ps
module telemetry_framer #(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned CH_W      = 12,
  parameter int unsigned PERIOD    = 1041667,
  parameter logic [7:0]  DELIM1    = 8'hAA,
  parameter logic [7:0]  DELIM2    = 8'h55,
  parameter bit          CHKSUM_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [NUM_CH*CH_W-1:0] ch_data,
  input  logic                   tx_done,
  input  logic                   clr_ovr,
  output logic                   trmt,
  output logic [7:0]             tx_data,
  output logic                   busy,
  output logic                   overrun
);

  localparam int unsigned BPC    = (CH_W + 7) / 8;
  localparam int unsigned CHB_W  = BPC * 8;
  localparam int unsigned NPAY   = NUM_CH * BPC;
  localparam int unsigned PAY_W  = NPAY * 8;
  localparam int unsigned SNAP_W = NUM_CH * CH_W;
  localparam int unsigned CK     = CHKSUM_EN ? 1 : 0;
  localparam int unsigned NBYTES = 2 + NPAY + CK;
  localparam int unsigned IDX_W  = $clog2(NBYTES);
  localparam int unsigned CNT_W  = $clog2(PERIOD);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

  state_t              state_q, state_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt;
  logic [IDX_W-1:0]    idx_q, idx_nxt, idx_inc;
  logic [SNAP_W-1:0]   snap_q, snap_nxt;
  logic [7:0]          acc_q, acc_nxt;
  logic                trmt_nxt, busy_nxt, ovr_nxt;
  logic [7:0]          tx_data_nxt, next_byte;
  logic [PAY_W-1:0]    pay;
  logic                tick;

  // Byte at frame position i; the checksum slot reads the running accumulator.
  function automatic logic [7:0] byte_at(input logic [IDX_W-1:0] i,
                                         input logic [PAY_W-1:0] p,
                                         input logic [7:0] acc);
    int unsigned ii;
    ii = 32'(i);
    if (ii == 0) return DELIM1;
    if (ii == 1) return DELIM2;
    if (ii < NPAY + 2) return p[(NPAY + 1 - ii) * 8 +: 8];
    return ~acc;
  endfunction

  function automatic logic is_payload(input logic [IDX_W-1:0] i);
    int unsigned ii;
    ii = 32'(i);
    return (ii >= 2) && (ii < NPAY + 2);
  endfunction

  // Snapshot flattened so channel 0 occupies the most significant bytes.
  always_comb begin
    pay = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      pay[(NUM_CH - 1 - k) * CHB_W +: CHB_W] = CHB_W'(snap_q[k * CH_W +: CH_W]);
    end
  end

  assign tick      = en && (cnt_q == CNT_W'(PERIOD - 1));
  assign idx_inc   = idx_q + IDX_W'(1);
  assign next_byte = byte_at(idx_inc, pay, acc_q);

  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = '0;
    idx_nxt     = idx_q;
    snap_nxt    = snap_q;
    acc_nxt     = acc_q;
    trmt_nxt    = 1'b0;
    tx_data_nxt = tx_data;
    busy_nxt    = busy;
    ovr_nxt     = overrun && !clr_ovr;

    if (en) cnt_nxt = tick ? '0 : cnt_q + CNT_W'(1);
    // A tick that lands while a frame is still in flight is lost; set beats clear.
    if (tick && busy) ovr_nxt = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (tick) begin
          snap_nxt    = ch_data;
          busy_nxt    = 1'b1;
          idx_nxt     = '0;
          acc_nxt     = '0;
          trmt_nxt    = 1'b1;
          tx_data_nxt = DELIM1;
          state_nxt   = LOAD;
        end
      end
      LOAD: state_nxt = WAIT;
      WAIT: begin
        if (tx_done) begin
          if (idx_q == IDX_W'(NBYTES - 1)) begin
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end else begin
            idx_nxt     = idx_inc;
            trmt_nxt    = 1'b1;
            tx_data_nxt = next_byte;
            if (is_payload(idx_inc)) acc_nxt = acc_q + next_byte;
            state_nxt   = LOAD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      acc_q   <= '0;
      trmt    <= 1'b0;
      tx_data <= 8'h00;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      idx_q   <= idx_nxt;
      snap_q  <= snap_nxt;
      acc_q   <= acc_nxt;
      trmt    <= trmt_nxt;
      tx_data <= tx_data_nxt;
      busy    <= busy_nxt;
      overrun <= ovr_nxt;
    end
  end

endmodule
